lcd_timed_ctrl: RTL and testbench
=================================

Name: lcd_timed_ctrl

Overview:
- Parametrised HD44780-class character-LCD bus controller; Avalon-MM slave between the NIOS II data master and the LCD pins.
- Replaces a purely combinational pin mapping with a cycle-accurate bus-cycle sequencer:
  - programmable address-setup, E-pulse and hold times;
  - waitrequest stall;
  - registered read capture;
  - 8-bit or 4-bit (two-nibble) bus mode.

Parameters:
- BUS_W, 8, LCD data bus width: 8 = single transfer; 4 = high nibble then low nibble on LCD_data[3:0].
- T_AS, 2, clk cycles RS/RW/data stable before E rises (min 1).
- T_PW, 12, clk cycles E held high (min 1).
- T_H, 2, clk cycles RS/RW/data held after E falls (min 1).
- CNT_W, 8, phase-counter width; every T_* must be < 2**CNT_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- address  in  2  [0]=RW (1=read), [1]=RS (1=data register)
- read  in  1  Avalon read request
- write  in  1  Avalon write request
- writedata  in  8  byte to LCD
- readdata  out  8  captured LCD byte, valid in DONE
- waitrequest  out  1  stall while sequencing
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  register select
- LCD_RW  out  1  read/write select
- LCD_data  inout  BUS_W  LCD data bus, tri-stated when not driving

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; LCD_E=0, LCD_RS=0, LCD_RW=0; LCD_data high-Z; readdata=0x00; counter=0; nibble flag=0.
- States:
  - IDLE -> SETUP when read|write.
  - SETUP (T_AS cycles) -> PULSE (T_PW cycles) -> HOLD (T_H cycles).
  - HOLD -> SETUP again if BUS_W=4 and first nibble; otherwise -> DONE.
  - DONE (1 cycle) -> IDLE.
- Request latching:
  - In IDLE the request is latched: RS, RW (address), write byte, op type.
  - Outputs are driven from the latched copies until DONE. Later changes to address/writedata are ignored.
- read and write both high: treated as write; RW forced 0.
- LCD_E: registered; high only in PULSE.
- LCD_RS/LCD_RW: registered; driven from the latch SETUP through HOLD. In IDLE/DONE they keep their last value.
- LCD_data on write:
  - Driven SETUP through HOLD.
  - BUS_W=8: full byte.
  - BUS_W=4: writedata[7:4] on the first nibble, [3:0] on the second.
- LCD_data on read: released (high-Z) throughout.
- Read capture:
  - Sampled on the last PULSE cycle.
  - BUS_W=4: first nibble -> readdata[7:4], second -> [3:0].
  - readdata holds its value until the next read completes.
- waitrequest = (read|write) & (state != DONE). Combinational from state; the transfer completes in DONE.
- Latency, request present in IDLE:
  - BUS_W=8: waitrequest high for 1+T_AS+T_PW+T_H cycles (defaults 17).
  - BUS_W=4: waitrequest high for 1+2*(T_AS+T_PW+T_H) cycles (defaults 33).
- Counter: loads T_*-1 on phase entry, decrements, advances the phase at 0. No wrap-around is possible.
- Reset mid-operation: E drops immediately (asynchronous), bus released, state IDLE. The partial LCD cycle is abandoned.
- Master dropping read/write mid-sequence: protocol violation. The sequence still completes; DONE is reached silently.

Optional Feature:
- Macro: LCD_BUSY_POLL_EN.
- When defined, every write is preceded by an automatic busy-flag poll:
  - A read cycle with RS=0, RW=1 (POLL_SETUP/POLL_PULSE/POLL_HOLD).
  - Repeated until the captured bit7 = 0; then the normal write sequence runs.
  - waitrequest stays high throughout the poll.
  - Poll results are not written to readdata.
- When undefined, writes start at SETUP directly and the poll states are not synthesised.

Decomposition:
- Package lcd_ctrl_pkg:
  - state enum (IDLE, SETUP, PULSE, HOLD, DONE, plus poll states under the macro);
  - default timing constants;
  - RW/RS bit-index constants.
- One sub-module, lcd_phase_timer: load/decrement/expire down-counter of width CNT_W, shared by all phases.

Test Plan:
- Write, BUS_W=8, defaults, address=0, writedata=0x38:
  - RS=0, RW=0 and LCD_data=0x38 appear 2 cycles before E rises;
  - E high exactly 12 cycles; data held 2 cycles after E falls;
  - waitrequest high 17 cycles, low in cycle 18.
- Read, BUS_W=8, address=3, LCD model drives 0x5A during PULSE:
  - LCD_data high-Z throughout; readdata=0x5A in DONE with waitrequest=0.
- Write, BUS_W=4, writedata=0xA7:
  - two E pulses; LCD_data[3:0]=0xA, then 0x7;
  - waitrequest high 33 cycles.
- Reset asserted during PULSE of a write:
  - LCD_E=0 the same cycle; LCD_data high-Z; next request starts cleanly from IDLE.
- read=write=1 with address=1:
  - executed as a write (RW=0, RS=0); readdata unchanged.
- With LCD_BUSY_POLL_EN, model returns bit7=1 for 3 polls then 0, write 0x01:
  - 4 poll read cycles precede the write pulse;
  - waitrequest high for the whole span; readdata unchanged.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared types and constants for the timed character-LCD controller.
// The state enum grows the busy-poll states only when LCD_BUSY_POLL_EN is defined.
package lcd_ctrl_pkg;

    // Default bus-cycle timing, in clk cycles
    localparam int DEF_T_AS  = 2;
    localparam int DEF_T_PW  = 12;
    localparam int DEF_T_H   = 2;
    localparam int DEF_CNT_W = 8;

    // Bit positions inside the Avalon address word
    localparam int ADDR_RW_BIT = 0;
    localparam int ADDR_RS_BIT = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
`ifdef LCD_BUSY_POLL_EN
        ,
        POLL_SETUP,
        POLL_PULSE,
        POLL_HOLD
`endif
    } state_e;

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter shared by every bus-cycle phase.
// Loaded with (phase length - 1) on phase entry; expired_o is high on the last cycle.
module lcd_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load on phase entry, otherwise count down and rest at zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_timed_ctrl.sv
// lcd_timed_ctrl: Avalon-MM slave that runs timed HD44780-style bus cycles
// (address setup, E pulse, hold) in 8-bit or two-nibble 4-bit mode.
// Build macro LCD_BUSY_POLL_EN: every write is preceded by busy-flag reads
// until bit7 reads back 0.
module lcd_timed_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int BUS_W = 8,
    parameter int T_AS  = DEF_T_AS,
    parameter int T_PW  = DEF_T_PW,
    parameter int T_H   = DEF_T_H,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [7:0]       writedata,
    output logic [7:0]       readdata,
    output logic             waitrequest,
    output logic             LCD_E,
    output logic             LCD_RS,
    output logic             LCD_RW,
    inout  wire  [BUS_W-1:0] LCD_data
);

    localparam logic [CNT_W-1:0] AS_M1 = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] PW_M1 = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] H_M1  = CNT_W'(T_H - 1);

    state_e           state_q, state_d;
    logic             rs_q, rw_q, is_wr_q, nib_q;
    logic [7:0]       wdata_q, rd_shadow_q, readdata_q;
    logic             lcd_e_q, lcd_rs_q, lcd_rw_q, drive_q;
    logic             tmr_load, tmr_exp;
    logic [CNT_W-1:0] tmr_val;
    logic [BUS_W-1:0] data_out;
    logic [7:0]       shadow_cap;
    logic             is_start, wr_sel, bus_phase_d;
`ifdef LCD_BUSY_POLL_EN
    logic             busy_q;
`endif

    lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

    // Bus-width specific data path: outgoing byte/nibble and read capture merge
    generate
        if (BUS_W == 8) begin : g_bus8
            assign data_out   = wdata_q;
            assign shadow_cap = LCD_data;
        end else begin : g_bus4
            assign data_out   = nib_q ? wdata_q[3:0] : wdata_q[7:4];
            assign shadow_cap = nib_q ? {rd_shadow_q[7:4], LCD_data}
                                      : {LCD_data, rd_shadow_q[3:0]};
        end
    endgenerate

    assign is_start    = (state_q == IDLE) && (read || write);
    assign wr_sel      = (state_q == IDLE) ? write : is_wr_q;
    assign bus_phase_d = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);

    // Phase sequencing and timer reload on every phase entry
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: if (read || write) begin
`ifdef LCD_BUSY_POLL_EN
                state_d = write ? POLL_SETUP : SETUP;
`else
                state_d = SETUP;
`endif
                tmr_load = 1'b1;
                tmr_val  = AS_M1;
            end
            SETUP: if (tmr_exp) begin
                state_d = PULSE; tmr_load = 1'b1; tmr_val = PW_M1;
            end
            PULSE: if (tmr_exp) begin
                state_d = HOLD; tmr_load = 1'b1; tmr_val = H_M1;
            end
            HOLD: if (tmr_exp) begin
                if (BUS_W == 4 && !nib_q) begin
                    state_d = SETUP; tmr_load = 1'b1; tmr_val = AS_M1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
`ifdef LCD_BUSY_POLL_EN
            POLL_SETUP: if (tmr_exp) begin
                state_d = POLL_PULSE; tmr_load = 1'b1; tmr_val = PW_M1;
            end
            POLL_PULSE: if (tmr_exp) begin
                state_d = POLL_HOLD; tmr_load = 1'b1; tmr_val = H_M1;
            end
            POLL_HOLD: if (tmr_exp) begin
                tmr_load = 1'b1;
                tmr_val  = AS_M1;
                if (BUS_W == 4 && !nib_q) state_d = POLL_SETUP;
                else                      state_d = busy_q ? POLL_SETUP : SETUP;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, request latch, registered pin drivers and read capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            is_wr_q     <= 1'b0;
            nib_q       <= 1'b0;
            wdata_q     <= 8'h00;
            rd_shadow_q <= 8'h00;
            readdata_q  <= 8'h00;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b0;
            drive_q     <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            busy_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef LCD_BUSY_POLL_EN
            lcd_e_q <= (state_d == PULSE) || (state_d == POLL_PULSE);
`else
            lcd_e_q <= (state_d == PULSE);
`endif
            drive_q <= wr_sel && bus_phase_d;
            if (is_start) begin
                // Write wins over read, and a write never asserts RW
                rs_q    <= address[ADDR_RS_BIT];
                rw_q    <= write ? 1'b0 : address[ADDR_RW_BIT];
                is_wr_q <= write;
                wdata_q <= writedata;
                nib_q   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
                lcd_rs_q <= write ? 1'b0 : address[ADDR_RS_BIT];
                lcd_rw_q <= write ? 1'b1 : address[ADDR_RW_BIT];
`else
                lcd_rs_q <= address[ADDR_RS_BIT];
                lcd_rw_q <= write ? 1'b0 : address[ADDR_RW_BIT];
`endif
            end
            if (state_q == PULSE && tmr_exp) begin
                rd_shadow_q <= shadow_cap;
            end
            if (state_q == HOLD && tmr_exp) begin
                nib_q <= (BUS_W == 4) && !nib_q;
                if (state_d == DONE && !is_wr_q) begin
                    readdata_q <= rd_shadow_q;
                end
            end
`ifdef LCD_BUSY_POLL_EN
            // Busy flag arrives on the first (or only) transfer of a poll
            if (state_q == POLL_PULSE && tmr_exp && !nib_q) begin
                busy_q <= LCD_data[BUS_W-1];
            end
            if (state_q == POLL_HOLD && tmr_exp) begin
                nib_q <= (BUS_W == 4) && !nib_q;
                if (state_d == SETUP) begin
                    lcd_rs_q <= rs_q;
                    lcd_rw_q <= rw_q;
                end
            end
`endif
        end
    end

    assign waitrequest = (read || write) && (state_q != DONE);
    assign readdata    = readdata_q;
    assign LCD_E       = lcd_e_q;
    assign LCD_RS      = lcd_rs_q;
    assign LCD_RW      = lcd_rw_q;
    assign LCD_data    = drive_q ? data_out : {BUS_W{1'bz}};

endmodule

// File: tb/tb_lcd_timed_ctrl.sv
// tb_lcd_timed_ctrl: directed and randomized transactions on an 8-bit and a
// 4-bit controller instance, checked cycle by cycle against a timeline model
// built from transfer lists (poll transfers included when LCD_BUSY_POLL_EN).
module tb_lcd_timed_ctrl;

    localparam int T_AS = 2;
    localparam int T_PW = 12;
    localparam int T_H  = 2;
`ifdef LCD_BUSY_POLL_EN
    localparam bit POLL_EN = 1'b1;
`else
    localparam bit POLL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       rd8 = 1'b0, wr8 = 1'b0, rd4 = 1'b0, wr4 = 1'b0;
    logic [1:0] ad8 = 2'b00, ad4 = 2'b00;
    logic [7:0] wd8 = 8'h00, wd4 = 8'h00;
    wire  [7:0] rdat8, rdat4;
    wire        wt8, wt4, e8, e4, rs8, rs4, rw8, rw4;
    wire  [7:0] bus8;
    wire  [3:0] bus4;
    logic [7:0] mval8 = 8'h00;
    logic [3:0] mval4 = 4'h0;

    // Released bus floats high; the LCD model drives only while RW=1 and E=1
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu8
        pullup (bus8[gi]);
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_pu4
        pullup (bus4[gi]);
    end
    assign bus8 = (e8 && rw8) ? mval8 : 8'bz;
    assign bus4 = (e4 && rw4) ? mval4 : 4'bz;

    lcd_timed_ctrl #(.BUS_W(8)) dut8 (
        .clk(clk), .reset(reset), .address(ad8), .read(rd8), .write(wr8),
        .writedata(wd8), .readdata(rdat8), .waitrequest(wt8),
        .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_data(bus8)
    );

    lcd_timed_ctrl #(.BUS_W(4)) dut4 (
        .clk(clk), .reset(reset), .address(ad4), .read(rd4), .write(wr4),
        .writedata(wd4), .readdata(rdat4), .waitrequest(wt4),
        .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_data(bus4)
    );

    int         vectors = 0;
    int         errs = 0;
    int         cur_u = 0;
    int         cur_k = 0;
    logic [7:0] ref_rd [2];
    logic       last_rs [2];
    logic       last_rw [2];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s (unit %0d cycle %0d): observed %02h expected %02h",
                   tag, cur_u, cur_k, obs, exp);
        end
    endtask

    // One Avalon transaction on unit u (0: 8-bit bus, 1: 4-bit bus).
    // busy = polls answering busy before the ready poll; abort_k = cycle to reset in (-1: none).
    task automatic run_txn(input int u, input logic rd, input logic wr, input logic [1:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rval,
                           input int busy, input int abort_k);
        int         n, L, T, npoll, j, o, last;
        logic       m_rs, m_rw, e_exp, rs_exp, rw_exp, in_ph;
        logic       o_w, o_e, o_rs, o_rw;
        logic [7:0] pull, o_bus, o_rd, tvj, bus_exp;
        int         kind [$];
        int         nib [$];
        logic [7:0] tv [$];
        n     = (u == 0) ? 1 : 2;
        L     = T_AS + T_PW + T_H;
        pull  = (u == 0) ? 8'hFF : 8'h0F;
        m_rs  = addr[1];
        m_rw  = wr ? 1'b0 : addr[0];
        npoll = (POLL_EN && wr) ? busy + 1 : 0;
        for (int p = 0; p < npoll; p++) begin
            for (int h = 0; h < n; h++) begin
                kind.push_back(0); nib.push_back(h);
                tv.push_back((p < busy) ? 8'h80 : 8'h00);
            end
        end
        for (int h = 0; h < n; h++) begin
            kind.push_back(1); nib.push_back(h); tv.push_back(rval);
        end
        T    = kind.size();
        last = T * L + 1;
        if (u == 0) begin rd8 = rd; wr8 = wr; ad8 = addr; wd8 = wdata; end
        else        begin rd4 = rd; wr4 = wr; ad4 = addr; wd4 = wdata; end
        for (int k = 0; k <= last; k++) begin
            cur_u = u;
            cur_k = k;
            in_ph = (k >= 1) && (k < last);
            j     = in_ph ? (k - 1) / L : 0;
            o     = in_ph ? (k - 1) % L : 0;
            if (in_ph) begin
                tvj   = tv[j];
                mval8 = tvj;
                mval4 = (nib[j] == 1) ? tvj[3:0] : tvj[7:4];
            end
            if (k == 2) begin
                // Latched request must ignore later address/data changes
                if (u == 0) begin ad8 = 2'($urandom); wd8 = 8'($urandom); end
                else        begin ad4 = 2'($urandom); wd4 = 8'($urandom); end
            end
            if (k == abort_k) begin
                #2 reset = 1'b1;
                #1;
                o_e   = (u == 0) ? e8 : e4;
                o_rs  = (u == 0) ? rs8 : rs4;
                o_bus = (u == 0) ? bus8 : {4'h0, bus4};
                o_rd  = (u == 0) ? rdat8 : rdat4;
                check("rst_lcd_e", {7'd0, o_e}, 8'h00);
                check("rst_lcd_rs", {7'd0, o_rs}, 8'h00);
                check("rst_bus_release", o_bus, pull);
                check("rst_readdata", o_rd, 8'h00);
                rd8 = 1'b0; wr8 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
                #2 reset = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    ref_rd[i] = 8'h00; last_rs[i] = 1'b0; last_rw[i] = 1'b0;
                end
                @(posedge clk); #1;
                return;
            end
            e_exp = in_ph && (o >= T_AS) && (o < T_AS + T_PW);
            if (!in_ph) begin
                rs_exp = (k == 0) ? last_rs[u] : m_rs;
                rw_exp = (k == 0) ? last_rw[u] : m_rw;
            end else if (kind[j] == 0) begin
                rs_exp = 1'b0; rw_exp = 1'b1;
            end else begin
                rs_exp = m_rs; rw_exp = m_rw;
            end
            #1;
            o_w   = (u == 0) ? wt8 : wt4;
            o_e   = (u == 0) ? e8 : e4;
            o_rs  = (u == 0) ? rs8 : rs4;
            o_rw  = (u == 0) ? rw8 : rw4;
            o_bus = (u == 0) ? bus8 : {4'h0, bus4};
            o_rd  = (u == 0) ? rdat8 : rdat4;
            check("waitrequest", {7'd0, o_w}, {7'd0, (k < last)});
            check("lcd_e", {7'd0, o_e}, {7'd0, e_exp});
            check("lcd_rs", {7'd0, o_rs}, {7'd0, rs_exp});
            check("lcd_rw", {7'd0, o_rw}, {7'd0, rw_exp});
            if (in_ph && kind[j] == 1 && wr) begin
                if (u == 0)           bus_exp = wdata;
                else if (nib[j] == 0) bus_exp = {4'h0, wdata[7:4]};
                else                  bus_exp = {4'h0, wdata[3:0]};
                check("bus_drive", o_bus, bus_exp);
            end else if (!e_exp) begin
                check("bus_release", o_bus, pull);
            end
            check("readdata", o_rd, (k == last && !wr) ? rval : ref_rd[u]);
            if (k == last) begin
                rd8 = 1'b0; wr8 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (!wr) ref_rd[u] = rval;
        last_rs[u] = m_rs;
        last_rw[u] = m_rw;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ref_rd[i] = 8'h00; last_rs[i] = 1'b0; last_rw[i] = 1'b0;
        end
        #2;
        check("reset_wait8", {7'd0, wt8}, 8'h00);
        check("reset_e8", {7'd0, e8}, 8'h00);
        check("reset_rs8", {7'd0, rs8}, 8'h00);
        check("reset_rw8", {7'd0, rw8}, 8'h00);
        check("reset_rdata8", rdat8, 8'h00);
        check("reset_bus8", bus8, 8'hFF);
        check("reset_e4", {7'd0, e4}, 8'h00);
        check("reset_rdata4", rdat4, 8'h00);
        check("reset_bus4", {4'h0, bus4}, 8'h0F);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        run_txn(0, 1'b0, 1'b1, 2'b00, 8'h38, 8'h00, 0, -1);       // 8-bit write 0x38
        run_txn(0, 1'b1, 1'b0, 2'b11, 8'h00, 8'h5A, 0, -1);       // 8-bit data read
        run_txn(1, 1'b0, 1'b1, 2'b00, 8'hA7, 8'h00, 0, -1);       // 4-bit write 0xA7
        run_txn(1, 1'b1, 1'b0, 2'b11, 8'h00, 8'hC3, 0, -1);       // 4-bit read
        run_txn(0, 1'b0, 1'b1, 2'b10, 8'h55, 8'h00, 0, 1 + T_AS + 3); // reset in PULSE
        run_txn(0, 1'b0, 1'b1, 2'b10, 8'h66, 8'h00, 0, -1);       // clean restart
        run_txn(0, 1'b1, 1'b0, 2'b01, 8'h00, 8'h9E, 0, -1);       // instruction read
        run_txn(0, 1'b1, 1'b1, 2'b01, 8'h3C, 8'hEE, 0, -1);       // read+write => write
        run_txn(0, 1'b0, 1'b1, 2'b00, 8'h01, 8'h00, 3, -1);       // busy 3 polls then write

        for (int t = 0; t < 20; t++) begin
            int         u, op, bz;
            logic [1:0] a;
            logic [7:0] d, r;
            u  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            bz = int'($urandom_range(0, 2));
            a  = 2'($urandom);
            d  = 8'($urandom);
            r  = 8'($urandom);
            case (op)
                0:       run_txn(u, 1'b1, 1'b0, {a[1], 1'b1}, d, r, 0, -1);
                1:       run_txn(u, 1'b0, 1'b1, {a[1], 1'b0}, d, r, bz, -1);
                default: run_txn(u, 1'b1, 1'b1, a, d, r, bz, -1);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
